cpu_exec_ctrl: RTL and testbench

Execution scheduler for the debug unit: sequences when the CPU may advance by issuing single-cycle clock-enable pulses. It replaces free-running divided CPU clocks with a clean enable on the system clock. It supports stop, continuous run at a programmable rate, single-step, breakpoint halt and error halt. It sits between the PDU button/state logic (command pulses, breakpoint address) and the CPU (enable, stop status, current PC).

---
 rtl/cpu_exec_ctrl.sv | 91 +++++++++
 tb/tb_cpu_exec_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_exec_ctrl.sv
// cpu_exec_ctrl: CPU clock-enable scheduler (stop/run/step/breakpoint/error halt).
// Define PDU_CYCLE_COUNT_EN to count issued cpu_ce pulses on cycle_cnt; otherwise it reads 0.
module cpu_exec_ctrl #(
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             cmd_run,
    input  logic             cmd_step,
    input  logic             cmd_stop,
    input  logic [DIV_W-1:0] div_cfg,
    input  logic             bp_valid,
    input  logic [31:0]      bp_addr,
    input  logic [31:0]      current_pc,
    input  logic             cpu_hold,
    input  logic             cpu_error,
    output logic             cpu_ce,
    output logic             cpu_stop,
    output logic             bp_hit,
    output logic [1:0]       state,
    output logic [31:0]      cycle_cnt
);
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, STEP = 2'b10, ERR = 2'b11} state_e;
    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d, div_lat_q, div_lat_d;
    logic             ce_q, bp_hit_q, bp_hit_d, bp_match;

    // PC is only meaningful the cycle after a pulse, so the match is gated by ce_q
    assign bp_match = (state_q == RUN) & ce_q & bp_valid & (current_pc == bp_addr);
    assign cpu_ce = ((state_q == RUN) & (div_cnt_q == div_lat_q) & ~cpu_hold & ~cmd_stop & ~cpu_error & ~bp_match)
                  | ((state_q == STEP) & ~cpu_hold & ~cpu_error);
    assign cpu_stop = (state_q == IDLE) | (state_q == ERR);
    assign bp_hit   = bp_hit_q;
    assign state    = state_q;

    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        div_lat_d = div_lat_q;
        bp_hit_d  = 1'b0;
        if (cpu_error) state_d = ERR;
        else begin
            case (state_q)
                IDLE: begin
                    if (!cmd_stop && cmd_step) state_d = STEP;
                    else if (!cmd_stop && cmd_run) begin
                        state_d   = RUN;
                        div_lat_d = div_cfg;
                        div_cnt_d = '0;
                    end
                end
                RUN: begin
                    if (cmd_stop) state_d = IDLE;
                    else if (bp_match) begin
                        state_d  = IDLE;
                        bp_hit_d = 1'b1;
                    end else if (!cpu_hold) div_cnt_d = (div_cnt_q == div_lat_q) ? '0 : div_cnt_q + 1'b1;
                end
                STEP: if (cmd_stop || !cpu_hold) state_d = IDLE;
                default: if (cmd_stop) state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            div_cnt_q <= '0;
            div_lat_q <= '0;
            ce_q      <= 1'b0;
            bp_hit_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            div_lat_q <= div_lat_d;
            ce_q      <= cpu_ce;
            bp_hit_q  <= bp_hit_d;
        end
    end

`ifdef PDU_CYCLE_COUNT_EN
    logic [31:0] cycle_cnt_q;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) cycle_cnt_q <= '0;
        else if (cpu_ce) cycle_cnt_q <= cycle_cnt_q + 32'd1;
    end
    assign cycle_cnt = cycle_cnt_q;
`else
    assign cycle_cnt = '0;
`endif
endmodule

// File: tb/tb_cpu_exec_ctrl.sv
// tb_cpu_exec_ctrl: directed test-plan steps plus randomized traffic against a countdown reference model.
module tb_cpu_exec_ctrl;
    localparam int DIV_W = 24;
    logic             clk = 1'b0, rstn = 1'b0;
    logic             cmd_run = 1'b0, cmd_step = 1'b0, cmd_stop = 1'b0;
    logic [DIV_W-1:0] div_cfg = '0;
    logic             bp_valid = 1'b0, cpu_hold = 1'b0, cpu_error = 1'b0;
    logic [31:0]      bp_addr = '0, pc = '0;
    logic             cpu_ce, cpu_stop, bp_hit;
    logic [1:0]       state;
    logic [31:0]      cycle_cnt;

    cpu_exec_ctrl #(.DIV_W(DIV_W)) dut (
        .clk(clk), .rstn(rstn), .cmd_run(cmd_run), .cmd_step(cmd_step), .cmd_stop(cmd_stop),
        .div_cfg(div_cfg), .bp_valid(bp_valid), .bp_addr(bp_addr), .current_pc(pc),
        .cpu_hold(cpu_hold), .cpu_error(cpu_error), .cpu_ce(cpu_ce), .cpu_stop(cpu_stop),
        .bp_hit(bp_hit), .state(state), .cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    int n_pass = 0, n_total = 0, cyc = 0, n_ce = 0, n_hit = 0, last_ce = 0, t0 = 0;
    // Reference: mode 0 idle, 1 run, 2 step, 3 error; m_wait counts non-held cycles until the next run pulse
    int          m_mode = 0, m_wait = 0, m_lat = 0;
    bit          m_chk = 0, m_hit = 0;
    logic [31:0] m_cnt = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
    endtask

    function automatic logic [31:0] exp_count(input logic [31:0] n);
`ifdef PDU_CYCLE_COUNT_EN
        return n;
`else
        return 32'd0 & n;
`endif
    endfunction

    task automatic model_reset();
        m_mode = 0; m_wait = 0; m_lat = 0; m_chk = 0; m_hit = 0; m_cnt = '0;
    endtask

    task automatic tick();
        bit bpm, ce;
        @(negedge clk);
        bpm = (m_mode == 1) && m_chk && bp_valid && (pc == bp_addr);
        ce = (m_mode == 1) ? (m_wait == 0 && !cpu_hold && !cmd_stop && !cpu_error && !bpm)
           : (m_mode == 2) ? (!cpu_hold && !cpu_error) : 1'b0;
        chk("cpu_ce", 32'(cpu_ce), 32'(ce));
        chk("state", 32'(state), 32'(m_mode));
        chk("cpu_stop", 32'(cpu_stop), 32'(m_mode == 0 || m_mode == 3));
        chk("bp_hit", 32'(bp_hit), 32'(m_hit));
        chk("cycle_cnt", cycle_cnt, exp_count(m_cnt));
        if (cpu_ce === 1'b1) begin n_ce++; last_ce = cyc; end
        if (bp_hit === 1'b1) n_hit++;
        m_hit = 0;
        m_chk = ce;
        if (ce) m_cnt = m_cnt + 1;
        if (cpu_error) m_mode = 3;
        else if (m_mode == 0) begin
            if (!cmd_stop && cmd_step) m_mode = 2;
            else if (!cmd_stop && cmd_run) begin m_mode = 1; m_lat = int'(div_cfg); m_wait = m_lat; end
        end else if (m_mode == 1) begin
            if (cmd_stop) m_mode = 0;
            else if (bpm) begin m_mode = 0; m_hit = 1; end
            else if (!cpu_hold) m_wait = (m_wait == 0) ? m_lat : m_wait - 1;
        end else if (m_mode == 2) begin
            if (cmd_stop || !cpu_hold) m_mode = 0;
        end else if (cmd_stop) m_mode = 0;
        if (!rstn) model_reset();
        @(posedge clk);
        #1;
        cyc++;
        if (ce && rstn) pc = pc + 32'd4;
        cmd_run = 1'b0; cmd_step = 1'b0; cmd_stop = 1'b0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        model_reset();
        tick();
        tick();
        rstn = 1'b1;
    endtask

    initial begin
        bit err;
        int r;
        // reset values
        do_reset();

        // run at div 4: first pulse 5 cycles after the run edge, then every 5
        div_cfg = 24'd4; cmd_run = 1'b1; t0 = cyc; tick();
        n_ce = 0;
        repeat (5) tick();
        chk("run_first_pulses", 32'(n_ce), 32'd1);
        chk("run_first_delay", 32'(last_ce - t0), 32'd5);
        repeat (15) tick();
        chk("run_pulses_20", 32'(n_ce), 32'd4);
        chk("run_last_delay", 32'(last_ce - t0), 32'd20);
        chk("run_state", 32'(state), 32'd1);
        chk("run_cpu_stop", 32'(cpu_stop), 32'd0);
        cmd_stop = 1'b1; tick(); tick();

        // breakpoint at 0x0C with div 0
        do_reset();
        pc = '0; div_cfg = '0; bp_valid = 1'b1; bp_addr = 32'h0C;
        cmd_run = 1'b1; tick();
        n_ce = 0; n_hit = 0;
        repeat (6) tick();
        chk("bp_pulses", 32'(n_ce), 32'd3);
        chk("bp_hit_cycles", 32'(n_hit), 32'd1);
        chk("bp_state", 32'(state), 32'd0);
        chk("bp_cpu_stop", 32'(cpu_stop), 32'd1);
        chk("bp_pc", pc, 32'h0C);
        chk("bp_cycle_cnt", cycle_cnt, exp_count(32'd3));
        cmd_run = 1'b1; tick();
        n_ce = 0;
        tick(); tick();
        chk("bp_resume_pulses", 32'(n_ce), 32'd2);
        chk("bp_resume_pc", pc, 32'h14);
        cmd_stop = 1'b1; tick(); tick();
        bp_valid = 1'b0;

        // three single steps
        n_ce = 0;
        for (int i = 0; i < 3; i++) begin
            cmd_step = 1'b1; t0 = cyc; tick();
            tick(); tick();
            chk("step_delay", 32'(last_ce - t0), 32'd1);
            chk("step_idle", 32'(state), 32'd0);
        end
        chk("step_pulses", 32'(n_ce), 32'd3);

        // hold freezes the divider for 10 cycles at div 2
        div_cfg = 24'd2; cmd_run = 1'b1; t0 = cyc; tick();
        repeat (4) tick();
        n_ce = 0; cpu_hold = 1'b1;
        repeat (10) tick();
        chk("hold_no_pulse", 32'(n_ce), 32'd0);
        cpu_hold = 1'b0;
        tick(); tick();
        chk("hold_resume_phase", 32'(last_ce - t0), 32'd16);
        cmd_stop = 1'b1; tick();

        // error halt on a pulse cycle, sticky while error is high
        div_cfg = '0; cmd_run = 1'b1; tick();
        tick();
        cpu_error = 1'b1; n_ce = 0; tick();
        chk("err_no_pulse", 32'(n_ce), 32'd0);
        chk("err_state", 32'(state), 32'd3);
        cmd_stop = 1'b1; tick(); tick();
        chk("err_stop_held", 32'(state), 32'd3);
        cpu_error = 1'b0; tick();
        chk("err_wait_stop", 32'(state), 32'd3);
        cmd_stop = 1'b1; tick();
        chk("err_cleared", 32'(state), 32'd0);

        // stop wins over run
        cmd_stop = 1'b1; cmd_run = 1'b1; tick(); tick();
        chk("stop_over_run", 32'(state), 32'd0);

        // asynchronous reset mid-run
        div_cfg = 24'd1; cmd_run = 1'b1; tick();
        repeat (4) tick();
        #2 rstn = 1'b0;
        #1;
        chk("rst_cpu_ce", 32'(cpu_ce), 32'd0);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_cpu_stop", 32'(cpu_stop), 32'd1);
        chk("rst_bp_hit", 32'(bp_hit), 32'd0);
        chk("rst_cycle_cnt", cycle_cnt, 32'd0);
        model_reset();
        tick();
        rstn = 1'b1;

        // randomized traffic
        err = 0;
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            cmd_run = (r < 8); cmd_step = (r >= 8 && r < 13); cmd_stop = (r >= 13 && r < 16);
            cpu_hold = ($urandom_range(0, 9) == 0);
            err = err ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 199) == 0);
            cpu_error = err;
            div_cfg = DIV_W'($urandom_range(0, 3));
            bp_valid = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) bp_addr = pc + 32'(4 * $urandom_range(1, 6));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
